// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the data RAM arbitration path.
// Requester ids double as the tag carried down the read-response pipeline.
package gpu_mem_pkg;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CORE = 1'b1
  } req_id_e;

  localparam int WORD_WIDTH     = 32;
  localparam int ADDRESS_WIDTH  = 16;
  localparam int RAM_ADDR_WIDTH = ADDRESS_WIDTH - 2;
  localparam int RSP_LATENCY    = 2;

  // One slot of the read-response shift register.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between host and core requesters.
// Grant is combinational from the valids; last_grant only moves on an accept.
module rr_arbiter2
  import gpu_mem_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    host_valid,
  input  logic    core_valid,
  output logic    host_grant,
  output logic    core_grant,
  output logic    accept,
  output req_id_e grant_id
);

  req_id_e last_grant;

  always_comb begin
    host_grant = 1'b0;
    core_grant = 1'b0;
    if (!reset) begin
      if (host_valid && core_valid) begin
        // Tie: the requester that did not win last time goes first.
        if (last_grant == REQ_CORE) begin
          host_grant = 1'b1;
        end else begin
          core_grant = 1'b1;
        end
      end else begin
        host_grant = host_valid;
        core_grant = core_valid;
      end
    end
  end

  assign accept   = host_grant | core_grant;
  assign grant_id = core_grant ? REQ_CORE : REQ_HOST;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= REQ_CORE;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Single arbitrated port onto the data BlockRam for the host loader and core load/store path.
// Accepted requests are registered onto the RAM pins; reads return two cycles after accept.
module data_ram_arbiter #(
  parameter int WORD_WIDTH     = gpu_mem_pkg::WORD_WIDTH,
  parameter int ADDRESS_WIDTH  = gpu_mem_pkg::ADDRESS_WIDTH,
  parameter int RAM_ADDR_WIDTH = gpu_mem_pkg::RAM_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      core_enable,

  input  logic                      host_req_valid,
  output logic                      host_req_ready,
  input  logic                      host_req_write,
  input  logic [ADDRESS_WIDTH-1:0]  host_req_address,
  input  logic [WORD_WIDTH-1:0]     host_req_wdata,
  output logic                      host_rsp_valid,
  output logic [WORD_WIDTH-1:0]     host_rsp_data,

  input  logic                      core_req_valid,
  output logic                      core_req_ready,
  input  logic                      core_req_write,
  input  logic [ADDRESS_WIDTH-1:0]  core_req_address,
  input  logic [WORD_WIDTH-1:0]     core_req_wdata,
  output logic                      core_rsp_valid,
  output logic [WORD_WIDTH-1:0]     core_rsp_data,

  output logic [RAM_ADDR_WIDTH-1:0] ram_address,
  output logic                      ram_write,
  output logic [WORD_WIDTH-1:0]     ram_write_data,
  input  logic [WORD_WIDTH-1:0]     ram_read_data
);

  import gpu_mem_pkg::*;

  logic                     core_valid_eff;
  logic                     accept;
  req_id_e                  grant_id;
  logic                     sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [WORD_WIDTH-1:0]    sel_wdata;
  logic                     unused_byte_offset;
  rsp_tag_t                 rsp_pipe [RSP_LATENCY];
  rsp_tag_t                 rsp_tail;

  assign core_valid_eff = core_req_valid & core_enable;

  rr_arbiter2 u_rr_arbiter2 (
    .clock      (clock),
    .reset      (reset),
    .host_valid (host_req_valid),
    .core_valid (core_valid_eff),
    .host_grant (host_req_ready),
    .core_grant (core_req_ready),
    .accept     (accept),
    .grant_id   (grant_id)
  );

  always_comb begin
    sel_write   = host_req_write;
    sel_address = host_req_address;
    sel_wdata   = host_req_wdata;
    if (grant_id == REQ_CORE) begin
      sel_write   = core_req_write;
      sel_address = core_req_address;
      sel_wdata   = core_req_wdata;
    end
  end

  // Byte offset within the word is dropped without a misalign error.
  assign unused_byte_offset = ^sel_address[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      ram_address    <= '0;
      ram_write      <= 1'b0;
      ram_write_data <= '0;
    end else if (accept) begin
      ram_address    <= sel_address[ADDRESS_WIDTH-1:2];
      ram_write      <= sel_write;
      ram_write_data <= sel_wdata;
    end else begin
      ram_write      <= 1'b0;
    end
  end

  // Tag shift aligned with the BlockRam's registered read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RSP_LATENCY; i++) begin
        rsp_pipe[i] <= '0;
      end
    end else begin
      rsp_pipe[0].valid <= accept & ~sel_write;
      rsp_pipe[0].id    <= grant_id;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign rsp_tail       = rsp_pipe[RSP_LATENCY-1];
  assign host_rsp_valid = rsp_tail.valid && (rsp_tail.id == REQ_HOST);
  assign core_rsp_valid = rsp_tail.valid && (rsp_tail.id == REQ_CORE);
  assign host_rsp_data  = host_rsp_valid ? ram_read_data : '0;
  assign core_rsp_data  = core_rsp_valid ? ram_read_data : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural registered-read BlockRam.
// Unwritten RAM words read back as {16'hC0DE, 2'b00, word_address}.
module tb_data_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        core_enable = 1'b1;
  logic        host_req_valid = 1'b0;
  logic        host_req_ready;
  logic        host_req_write = 1'b0;
  logic [15:0] host_req_address = '0;
  logic [31:0] host_req_wdata = '0;
  logic        host_rsp_valid;
  logic [31:0] host_rsp_data;
  logic        core_req_valid = 1'b0;
  logic        core_req_ready;
  logic        core_req_write = 1'b0;
  logic [15:0] core_req_address = '0;
  logic [31:0] core_req_wdata = '0;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_data;
  logic [13:0] ram_address;
  logic        ram_write;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] mem [0:16383];
  bit          wr_flag [0:16383];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_write) begin
      mem[ram_address]     <= ram_write_data;
      wr_flag[ram_address] <= 1'b1;
    end
    ram_read_data <= wr_flag[ram_address] ? mem[ram_address] : {16'hC0DE, 2'b00, ram_address};
  end

  data_ram_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .core_enable      (core_enable),
    .host_req_valid   (host_req_valid),
    .host_req_ready   (host_req_ready),
    .host_req_write   (host_req_write),
    .host_req_address (host_req_address),
    .host_req_wdata   (host_req_wdata),
    .host_rsp_valid   (host_rsp_valid),
    .host_rsp_data    (host_rsp_data),
    .core_req_valid   (core_req_valid),
    .core_req_ready   (core_req_ready),
    .core_req_write   (core_req_write),
    .core_req_address (core_req_address),
    .core_req_wdata   (core_req_wdata),
    .core_rsp_valid   (core_rsp_valid),
    .core_rsp_data    (core_rsp_data),
    .ram_address      (ram_address),
    .ram_write        (ram_write),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  task automatic idle_inputs();
    host_req_valid   = 1'b0;
    host_req_write   = 1'b0;
    host_req_address = '0;
    host_req_wdata   = '0;
    core_req_valid   = 1'b0;
    core_req_write   = 1'b0;
    core_req_address = '0;
    core_req_wdata   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    host_req_valid = 1'b1;
    core_req_valid = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checks_total++;
    if (host_req_ready !== 1'b0) $display("FAIL reset_host_ready got=%b want=0", host_req_ready);
    else checks_passed++;
    checks_total++;
    if (core_req_ready !== 1'b0) $display("FAIL reset_core_ready got=%b want=0", core_req_ready);
    else checks_passed++;
    checks_total++;
    if ({ram_address, ram_write, ram_write_data} !== '0)
      $display("FAIL reset_ram_pins got addr=%h we=%b wd=%h want all 0", ram_address, ram_write, ram_write_data);
    else checks_passed++;
    checks_total++;
    if ({host_rsp_valid, core_rsp_valid, host_rsp_data, core_rsp_data} !== '0)
      $display("FAIL reset_rsp got hv=%b cv=%b hd=%h cd=%h want all 0", host_rsp_valid, core_rsp_valid, host_rsp_data, core_rsp_data);
    else checks_passed++;
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clock);
    host_req_valid = 1'b1; host_req_write = 1'b1;
    host_req_address = 16'h0010; host_req_wdata = 32'hDEADBEEF;
    #1;
    checks_total++;
    if (host_req_ready !== 1'b1) $display("FAIL wr_ready got=%b want=1", host_req_ready);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    checks_total++;
    if ({ram_write, ram_address, ram_write_data} !== {1'b1, 14'h0004, 32'hDEADBEEF})
      $display("FAIL wr_issue got we=%b addr=%h wd=%h want 1/0004/deadbeef", ram_write, ram_address, ram_write_data);
    else checks_passed++;
    host_req_write = 1'b0;
    #1;
    checks_total++;
    if (host_req_ready !== 1'b1) $display("FAIL rd_ready got=%b want=1", host_req_ready);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    #1;
    checks_total++;
    if ({ram_write, ram_address} !== {1'b0, 14'h0004})
      $display("FAIL rd_issue got we=%b addr=%h want 0/0004", ram_write, ram_address);
    else checks_passed++;
    checks_total++;
    if (host_rsp_valid !== 1'b0) $display("FAIL rd_early_rsp got=%b want=0", host_rsp_valid);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    #1;
    checks_total++;
    if ({host_rsp_valid, core_rsp_valid, host_rsp_data} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL rd_rsp got hv=%b cv=%b hd=%h want 1/0/deadbeef", host_rsp_valid, core_rsp_valid, host_rsp_data);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    #1;
    checks_total++;
    if (host_rsp_valid !== 1'b0) $display("FAIL rd_rsp_pulse got=%b want=0", host_rsp_valid);
    else checks_passed++;
  endtask

  task automatic test_alternate();
    logic [15:0] h_addr [0:2] = '{16'h0100, 16'h0104, 16'h0108};
    logic [15:0] c_addr [0:1] = '{16'h0200, 16'h0204};
    bit          exp_hg [0:6] = '{1, 0, 1, 0, 1, 0, 0};
    bit          exp_cg [0:6] = '{0, 1, 0, 1, 0, 0, 0};
    bit          exp_hr [0:6] = '{0, 0, 1, 0, 1, 0, 1};
    bit          exp_cr [0:6] = '{0, 0, 0, 1, 0, 1, 0};
    logic [31:0] exp_d  [0:6] = '{32'h0, 32'h0, 32'hC0DE0040, 32'hC0DE0080,
                                  32'hC0DE0041, 32'hC0DE0081, 32'hC0DE0042};
    int hi = 0;
    int ci = 0;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clock) ;
      host_req_valid   = (hi < 3);
      host_req_address = (hi < 3) ? h_addr[hi] : 16'h0;
      core_req_valid   = (ci < 2);
      core_req_address = (ci < 2) ? c_addr[ci] : 16'h0;
      #1;
      checks_total++;
      if ({host_req_ready, core_req_ready} !== {exp_hg[c], exp_cg[c]})
        $display("FAIL alt_grant c=%0d got h=%b c=%b want h=%b c=%b", c, host_req_ready, core_req_ready, exp_hg[c], exp_cg[c]);
      else checks_passed++;
      checks_total++;
      if ({host_rsp_valid, core_rsp_valid} !== {exp_hr[c], exp_cr[c]})
        $display("FAIL alt_rsp_valid c=%0d got h=%b c=%b want h=%b c=%b", c, host_rsp_valid, core_rsp_valid, exp_hr[c], exp_cr[c]);
      else checks_passed++;
      if (exp_hr[c]) begin
        checks_total++;
        if (host_rsp_data !== exp_d[c]) $display("FAIL alt_host_data c=%0d got=%h want=%h", c, host_rsp_data, exp_d[c]);
        else checks_passed++;
      end
      if (exp_cr[c]) begin
        checks_total++;
        if (core_rsp_data !== exp_d[c]) $display("FAIL alt_core_data c=%0d got=%h want=%h", c, core_rsp_data, exp_d[c]);
        else checks_passed++;
      end
      hi += int'(exp_hg[c]);
      ci += int'(exp_cg[c]);
      @(posedge clock);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_core_masked();
    @(negedge clock);
    core_enable = 1'b0;
    core_req_valid = 1'b1; core_req_write = 1'b1;
    core_req_address = 16'h0040; core_req_wdata = 32'hBAD0BAD0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks_total++;
      if ({core_req_ready, ram_write} !== 2'b00)
        $display("FAIL masked c=%0d got ready=%b we=%b want 0/0", c, core_req_ready, ram_write);
      else checks_passed++;
      @(posedge clock);
      @(negedge clock);
    end
    idle_inputs();
    core_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    core_req_valid = 1'b1; core_req_write = 1'b0; core_req_address = 16'h0020;
    #1;
    checks_total++;
    if (core_req_ready !== 1'b1) $display("FAIL rstmid_ready got=%b want=1", core_req_ready);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    #1;
    checks_total++;
    if (ram_address !== 14'h0008) $display("FAIL rstmid_issue got=%h want=0008", ram_address);
    else checks_passed++;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      @(negedge clock);
      #1;
      checks_total++;
      if ({core_rsp_valid, host_rsp_valid, core_rsp_data, ram_address, ram_write, ram_write_data} !== '0)
        $display("FAIL rstmid_outputs c=%0d got cv=%b hv=%b cd=%h addr=%h we=%b want all 0",
                 c, core_rsp_valid, host_rsp_valid, core_rsp_data, ram_address, ram_write);
      else checks_passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_raw();
    @(negedge clock);
    core_req_valid = 1'b1; core_req_write = 1'b1;
    core_req_address = 16'h0004; core_req_wdata = 32'h12345678;
    #1;
    checks_total++;
    if (core_req_ready !== 1'b1) $display("FAIL raw_wr_ready got=%b want=1", core_req_ready);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    core_req_write = 1'b0; core_req_address = 16'h0007;
    #1;
    checks_total++;
    if ({core_req_ready, ram_write} !== 2'b11) $display("FAIL raw_rd_ready got ready=%b we=%b want 1/1", core_req_ready, ram_write);
    else checks_passed++;
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    @(posedge clock);
    @(negedge clock);
    #1;
    checks_total++;
    if ({core_rsp_valid, host_rsp_valid, core_rsp_data} !== {1'b1, 1'b0, 32'h12345678})
      $display("FAIL raw_rsp got cv=%b hv=%b cd=%h want 1/0/12345678", core_rsp_valid, host_rsp_valid, core_rsp_data);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      host_req_valid   = (c < 8);
      host_req_write   = 1'b0;
      host_req_address = (c < 8) ? 16'h0300 + 16'(4 * c) : 16'h0;
      #1;
      if (c < 8) begin
        checks_total++;
        if (host_req_ready !== 1'b1) $display("FAIL b2b_ready c=%0d got=%b want=1", c, host_req_ready);
        else checks_passed++;
      end
      if (c >= 2 && c < 10) begin
        checks_total++;
        if ({host_rsp_valid, host_rsp_data} !== {1'b1, 32'hC0DE00C0 + 32'(c - 2)})
          $display("FAIL b2b_rsp c=%0d got v=%b d=%h want 1/%h", c, host_rsp_valid, host_rsp_data, 32'hC0DE00C0 + 32'(c - 2));
        else checks_passed++;
      end
      if (c == 10) begin
        checks_total++;
        if (host_rsp_valid !== 1'b0) $display("FAIL b2b_tail got=%b want=0", host_rsp_valid);
        else checks_passed++;
      end
      @(posedge clock);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_core_masked();
    test_reset_mid();
    test_raw();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
